// File: rtl/seg7_scan_2digit.sv
// Two-digit multiplexed 7-segment display stage for a wrapping down counter.
// Also flashes wrap_led for a fixed number of clocks when the counter wraps from 0.
module seg7_scan_2digit #(
    parameter int W              = 5,
    parameter int SCAN_DIV       = 4,
    parameter int FLASH_LEN      = 8,
    parameter int BLANK_LZ       = 1,
    parameter int ACTIVE_LOW_SEG = 1
) (
    input  logic         ck,
    input  logic         rs,
    input  logic [W-1:0] a,
    output logic [6:0]   seg,
    output logic [1:0]   dig,
    output logic         wrap_led
);

    localparam int SC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FC_W = $clog2(FLASH_LEN + 1);
    localparam logic [6:0] SEG_OFF = (ACTIVE_LOW_SEG != 0) ? 7'h7F : 7'h00;

    typedef enum logic {
        IDLE,
        FLASH
    } state_t;

    logic [W-1:0]    val_q;
    logic            first_q;
    logic [SC_W-1:0] scan_cnt;
    logic            sel;
    logic [FC_W-1:0] flash_cnt;
    state_t          fsm;

    logic [3:0] tens;
    logic [3:0] units;
    logic       wrap_ev;
    logic [6:0] seg_d;
    logic [1:0] dig_d;

    function automatic logic [6:0] seg_lut(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0111111;
            4'd1:    s = 7'b0000110;
            4'd2:    s = 7'b1011011;
            4'd3:    s = 7'b1001111;
            4'd4:    s = 7'b1100110;
            4'd5:    s = 7'b1101101;
            4'd6:    s = 7'b1111101;
            4'd7:    s = 7'b0000111;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1101111;
            default: s = 7'b0000000;
        endcase
        return (ACTIVE_LOW_SEG != 0) ? ~s : s;
    endfunction

    // Digit split, wrap detection and next segment/digit drive for the currently selected digit.
    always_comb begin
        tens    = 4'(val_q / W'(10));
        units   = 4'(val_q % W'(10));
        wrap_ev = first_q && (val_q == '0) && (a != '0);
        seg_d   = SEG_OFF;
        dig_d   = 2'b11;
        if (!sel) begin
            dig_d = 2'b10;
            seg_d = seg_lut(units);
        end else if ((BLANK_LZ != 0) && (tens == 4'd0)) begin
            dig_d = 2'b11;
            seg_d = SEG_OFF;
        end else begin
            dig_d = 2'b01;
            seg_d = seg_lut(tens);
        end
    end

    // Sampling on the rising edge lands mid-period for a counter that updates on the falling edge.
    always_ff @(posedge ck or negedge rs) begin
        if (!rs) begin
            val_q    <= '0;
            first_q  <= 1'b0;
            scan_cnt <= '0;
            sel      <= 1'b0;
            seg      <= SEG_OFF;
            dig      <= 2'b11;
        end else begin
            val_q   <= a;
            first_q <= 1'b1;
            seg     <= seg_d;
            dig     <= dig_d;
            if (scan_cnt == SC_W'(SCAN_DIV - 1)) begin
                scan_cnt <= '0;
                sel      <= ~sel;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
        end
    end

    // A wrap on the expiry edge reloads rather than dropping out, so the LED never glitches low.
    always_ff @(posedge ck or negedge rs) begin
        if (!rs) begin
            fsm       <= IDLE;
            flash_cnt <= '0;
            wrap_led  <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (wrap_ev) begin
                        fsm       <= FLASH;
                        flash_cnt <= FC_W'(FLASH_LEN - 1);
                        wrap_led  <= 1'b1;
                    end
                end
                FLASH: begin
                    if (wrap_ev) begin
                        flash_cnt <= FC_W'(FLASH_LEN - 1);
                        wrap_led  <= 1'b1;
                    end else if (flash_cnt == '0) begin
                        fsm      <= IDLE;
                        wrap_led <= 1'b0;
                    end else begin
                        flash_cnt <= flash_cnt - 1'b1;
                        wrap_led  <= 1'b1;
                    end
                end
                default: begin
                    fsm       <= IDLE;
                    flash_cnt <= '0;
                    wrap_led  <= 1'b0;
                end
            endcase
        end
    end

endmodule
